// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage. Holds the PC and drives it as the instruction
// address. Each accepted instruction is latched, with its PC+4, into the
// IF/ID register. Redirects load a new PC and squash IF/ID. Stalls freeze
// the PC and IF/ID. Misses insert a bubble.
//
// Optional feature (macro FETCH_HALT_DETECT_EN):
//   When defined, an accepted instruction with opcode 6'h3F latches normally.
//   It then parks the stage in HALTED until a redirect or reset.
//   When undefined, that opcode is an ordinary instruction and halt_out is 0.
//
// Ports:
//   CLK          in   rising-edge clock
//   RST          in   asynchronous active-high reset
//   ihit         in   instruction memory returned iload this cycle
//   iload        in   instruction word from memory
//   stall        in   hazard hold (freeze PC and IF/ID)
//   redirect     in   taken branch/jump (load redirect_pc, squash IF/ID)
//   redirect_pc  in   redirect target (low two bits ignored)
//   imemREN      out  instruction read request (high in FETCH)
//   imemaddr     out  instruction address (current PC)
//   instr_out    out  IF/ID instruction
//   PCInc_out    out  IF/ID PC+4
//   valid_out    out  IF/ID holds a real instruction
//   halt_out     out  registered HALTED indication
//   fetch_count  out  instructions accepted into IF/ID
// ----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic [31:0] iload,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    output logic [31:0] instr_out,
    output logic [31:0] PCInc_out,
    output logic        valid_out,
    output logic        halt_out,
    output logic [31:0] fetch_count
);

    typedef enum logic [0:0] {StFetch, StHalted} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcinc_q, pcinc_d;
    logic        valid_q, valid_d;
    logic [31:0] count_q, count_d;
    logic [31:0] pc_plus4;

    // Redirect targets are forced word-aligned, so the low bits are dropped.
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pcinc_d = pcinc_q;
        valid_d = valid_q;
        count_d = count_q;

        if (redirect) begin
            pc_d    = {redirect_pc[31:2], 2'b00};
            instr_d = 32'h0;
            pcinc_d = 32'h0;
            valid_d = 1'b0;
            state_d = StFetch;
        end else if (state_q == StHalted) begin
            // Parked: everything holds until redirect or reset.
        end else if (stall) begin
            // Hazard hold: ihit is ignored so the same word is re-fetched.
        end else if (ihit) begin
            instr_d = iload;
            pcinc_d = pc_plus4;
            valid_d = 1'b1;
            count_d = count_q + 32'd1;
`ifdef FETCH_HALT_DETECT_EN
            // The halt word still reaches decode, but the PC stops on it.
            if (iload[31:26] == 6'h3F) begin
                state_d = StHalted;
            end else begin
                pc_d = pc_plus4;
            end
`else
            pc_d = pc_plus4;
`endif
        end else begin
            instr_d = 32'h0;
            pcinc_d = 32'h0;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StFetch;
            pc_q    <= PC_RESET;
            instr_q <= 32'h0;
            pcinc_q <= 32'h0;
            valid_q <= 1'b0;
            count_q <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pcinc_q <= pcinc_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

`ifdef FETCH_HALT_DETECT_EN
    logic halt_q, halt_d;

    assign halt_d = (state_d == StHalted);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            halt_q <= 1'b0;
        end else begin
            halt_q <= halt_d;
        end
    end

    assign halt_out = halt_q;
`else
    assign halt_out = 1'b0;
`endif

    assign imemREN     = (state_q == StFetch);
    assign imemaddr    = pc_q;
    assign instr_out   = instr_q;
    assign PCInc_out   = pcinc_q;
    assign valid_out   = valid_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_fetch_stage
//
// Table-driven bench for fetch_stage. Each record holds one cycle of inputs
// and the outputs expected after the next rising edge. Expected records are
// queued when stimulus is driven and popped for comparison after the edge.
// Hand-written sequences cover asynchronous reset mid-miss and in HALTED.
// ----------------------------------------------------------------------------
module tb_fetch_stage;

`ifdef FETCH_HALT_DETECT_EN
    localparam bit HD = 1'b1;
`else
    localparam bit HD = 1'b0;
`endif

    typedef struct {
        logic        ihit;
        logic [31:0] iload;
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic [31:0] e_addr;
        logic [31:0] e_instr;
        logic [31:0] e_pcinc;
        logic        e_valid;
        logic [31:0] e_cnt;
        logic        e_halt;
        logic        e_ren;
    } vec_t;

    logic        CLK;
    logic        RST;
    logic        ihit;
    logic [31:0] iload;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic [31:0] instr_out;
    logic [31:0] PCInc_out;
    logic        valid_out;
    logic        halt_out;
    logic [31:0] fetch_count;

    int checks;
    int failures;

    vec_t vecs[$];
    vec_t exp_q[$];

    fetch_stage #(
        .PC_RESET(32'h0000_0000)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .ihit       (ihit),
        .iload      (iload),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imemREN    (imemREN),
        .imemaddr   (imemaddr),
        .instr_out  (instr_out),
        .PCInc_out  (PCInc_out),
        .valid_out  (valid_out),
        .halt_out   (halt_out),
        .fetch_count(fetch_count)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%h exp=%h", name, idx, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic hi, input logic [31:0] ld, input logic st,
                                input logic rd, input logic [31:0] rp,
                                input logic [31:0] ea, input logic [31:0] ei,
                                input logic [31:0] ep, input logic ev,
                                input logic [31:0] ec, input logic eh, input logic er);
        vec_t v;
        v.ihit = hi;  v.iload = ld;  v.stall = st;  v.redir = rd;  v.rpc = rp;
        v.e_addr = ea; v.e_instr = ei; v.e_pcinc = ep; v.e_valid = ev;
        v.e_cnt = ec; v.e_halt = eh; v.e_ren = er;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        ihit        = v.ihit;
        iload       = v.iload;
        stall       = v.stall;
        redirect    = v.redir;
        redirect_pc = v.rpc;
    endtask

    task automatic compare_out(input int idx, input vec_t e);
        chk("imemaddr", idx, imemaddr, e.e_addr);
        chk("instr_out", idx, instr_out, e.e_instr);
        chk("PCInc_out", idx, PCInc_out, e.e_pcinc);
        chk("valid_out", idx, {31'h0, valid_out}, {31'h0, e.e_valid});
        chk("fetch_count", idx, fetch_count, e.e_cnt);
        chk("halt_out", idx, {31'h0, halt_out}, {31'h0, e.e_halt});
        chk("imemREN", idx, {31'h0, imemREN}, {31'h0, e.e_ren});
    endtask

    initial begin
        vec_t e;
        logic [31:0] c16;

        checks   = 0;
        failures = 0;
        RST         = 1'b1;
        ihit        = 1'b0;
        iload       = 32'h0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;

        c16 = HD ? 32'd7 : 32'd8;

        //          ihit iload          st rd rpc            addr           instr          pcinc          v  cnt        h   ren
        vecs.push_back(mk(1, 32'hA000_000A, 0, 0, 32'h0,        32'h4,         32'hA000_000A, 32'h4,         1, 32'd1,     0,  1));
        vecs.push_back(mk(1, 32'hB000_000B, 0, 0, 32'h0,        32'h8,         32'hB000_000B, 32'h8,         1, 32'd2,     0,  1));
        vecs.push_back(mk(1, 32'hDEAD_0001, 1, 0, 32'h0,        32'h8,         32'hB000_000B, 32'h8,         1, 32'd2,     0,  1));
        vecs.push_back(mk(1, 32'hDEAD_0002, 1, 0, 32'h0,        32'h8,         32'hB000_000B, 32'h8,         1, 32'd2,     0,  1));
        vecs.push_back(mk(1, 32'hC000_000C, 0, 0, 32'h0,        32'hC,         32'hC000_000C, 32'hC,         1, 32'd3,     0,  1));
        vecs.push_back(mk(1, 32'hDEAD_0003, 1, 1, 32'h43,       32'h40,        32'h0,         32'h0,         0, 32'd3,     0,  1));
        vecs.push_back(mk(1, 32'hD000_000D, 0, 0, 32'h0,        32'h44,        32'hD000_000D, 32'h44,        1, 32'd4,     0,  1));
        vecs.push_back(mk(0, 32'h0,         0, 1, 32'h4,        32'h4,         32'h0,         32'h0,         0, 32'd4,     0,  1));
        vecs.push_back(mk(0, 32'hDEAD_0004, 0, 0, 32'h0,        32'h4,         32'h0,         32'h0,         0, 32'd4,     0,  1));
        vecs.push_back(mk(0, 32'hDEAD_0005, 0, 0, 32'h0,        32'h4,         32'h0,         32'h0,         0, 32'd4,     0,  1));
        vecs.push_back(mk(1, 32'hE000_000E, 0, 0, 32'h0,        32'h8,         32'hE000_000E, 32'h8,         1, 32'd5,     0,  1));
        vecs.push_back(mk(0, 32'h0,         0, 0, 32'h0,        32'h8,         32'h0,         32'h0,         0, 32'd5,     0,  1));
        vecs.push_back(mk(0, 32'h0,         0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0,        32'h0,         0, 32'd5,     0,  1));
        vecs.push_back(mk(1, 32'hF000_000F, 0, 0, 32'h0,        32'h0,         32'hF000_000F, 32'h0,         1, 32'd6,     0,  1));
        // Halt opcode at PC 0, then a further ihit that HALTED must ignore.
        vecs.push_back(mk(1, 32'hFC00_0000, 0, 0, 32'h0,        HD ? 32'h0 : 32'h4, 32'hFC00_0000, 32'h4,    1, 32'd7,     HD, !HD));
        vecs.push_back(mk(1, 32'h9000_0009, 0, 0, 32'h0,        HD ? 32'h0 : 32'h8,
                          HD ? 32'hFC00_0000 : 32'h9000_0009, HD ? 32'h4 : 32'h8,       1, c16,       HD, !HD));
        vecs.push_back(mk(0, 32'h0,         0, 1, 32'h100,      32'h100,       32'h0,         32'h0,         0, c16,       0,  1));
        vecs.push_back(mk(1, 32'h8000_0008, 0, 0, 32'h0,        32'h104,       32'h8000_0008, 32'h104,       1, c16 + 1,   0,  1));

        // Reset state, asynchronous.
        #2;
        chk("rst_addr", 0, imemaddr, 32'h0);
        chk("rst_instr", 0, instr_out, 32'h0);
        chk("rst_pcinc", 0, PCInc_out, 32'h0);
        chk("rst_valid", 0, {31'h0, valid_out}, 32'h0);
        chk("rst_halt", 0, {31'h0, halt_out}, 32'h0);
        chk("rst_cnt", 0, fetch_count, 32'h0);
        chk("rst_ren", 0, {31'h0, imemREN}, 32'h1);
        @(negedge CLK);
        RST = 1'b0;

        foreach (vecs[i]) begin
            @(negedge CLK);
            drive(vecs[i]);
            exp_q.push_back(vecs[i]);
            @(posedge CLK);
            #1;
            if (exp_q.size() == 0) begin
                chk("sb_empty", i, 32'h1, 32'h0);
            end else begin
                e = exp_q.pop_front();
                compare_out(i, e);
            end
        end

        // RST pulsed mid-miss: PC returns to PC_RESET without a clock edge.
        @(negedge CLK);
        ihit = 1'b0; stall = 1'b0; redirect = 1'b0;
        #2;
        RST = 1'b1;
        #1;
        chk("arst_addr", 0, imemaddr, 32'h0);
        chk("arst_cnt", 0, fetch_count, 32'h0);
        chk("arst_valid", 0, {31'h0, valid_out}, 32'h0);
        @(negedge CLK);
        RST = 1'b0;

        // Halt word, then reset inside HALTED (or after it in the default build).
        ihit  = 1'b1;
        iload = 32'hFC00_1234;
        @(posedge CLK);
        #1;
        chk("h_halt", 0, {31'h0, halt_out}, {31'h0, HD});
        chk("h_instr", 0, instr_out, 32'hFC00_1234);
        @(negedge CLK);
        ihit = 1'b0;
        #2;
        RST = 1'b1;
        #1;
        chk("hrst_halt", 0, {31'h0, halt_out}, 32'h0);
        chk("hrst_ren", 0, {31'h0, imemREN}, 32'h1);
        chk("hrst_addr", 0, imemaddr, 32'h0);
        @(negedge CLK);
        RST   = 1'b0;
        ihit  = 1'b1;
        iload = 32'h1234_5678;
        @(posedge CLK);
        #1;
        chk("post_instr", 0, instr_out, 32'h1234_5678);
        chk("post_pcinc", 0, PCInc_out, 32'h4);
        chk("post_addr", 0, imemaddr, 32'h4);
        chk("post_cnt", 0, fetch_count, 32'h1);
        @(negedge CLK);
        ihit = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter PC_RESET, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 SHALL have port CLK  input  1  rising-edge clock.
REQ-003 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port ihit  input  1  instruction memory returned iload this cycle.
REQ-005 SHALL have port iload  input  32  instruction word from instruction memory.
REQ-006 SHALL have port stall  input  1  hazard hold: freeze PC and the IF/ID latch.
REQ-007 SHALL have port redirect  input  1  taken branch/jump: load new PC, squash the IF/ID latch.
REQ-008 SHALL have port redirect_pc  input  32  redirect target.
REQ-009 SHALL have port imemREN  output  1  instruction read request.
REQ-010 SHALL have port imemaddr  output  32  instruction address, equal to current PC.
REQ-011 SHALL have port instr_out  output  32  latched instruction to decode.
REQ-012 SHALL have port PCInc_out  output  32  latched PC+4 of instr_out.
REQ-013 SHALL have port valid_out  output  1  instr_out holds a real instruction, not a bubble.
REQ-014 SHALL have port halt_out  output  1  registered; high in the HALTED state.
REQ-015 SHALL have port fetch_count  output  32  count of instructions accepted into IF/ID.

Function
REQ-016 SHALL keep a 32-bit PC register; imemaddr = PC combinationally.
REQ-017 SHALL assert imemREN in FETCH and deassert it in HALTED.
REQ-018 SHALL use event priority per edge: redirect > stall > ihit > miss.
REQ-019 On redirect: PC <= {redirect_pc[31:2],2'b00}; IF/ID <= bubble (instr_out 0, PCInc_out 0, valid_out 0); state <= FETCH; fetch_count unchanged.
REQ-020 On stall without redirect: PC, IF/ID, state and fetch_count SHALL hold, even if ihit is high.
REQ-021 On ihit without stall/redirect in FETCH: PC <= PC+4; instr_out <= iload; PCInc_out <= PC+4; valid_out <= 1; fetch_count += 1.
REQ-022 On a miss (!ihit) without stall/redirect: PC holds; IF/ID <= bubble.
REQ-023 PC+4 and fetch_count SHALL wrap modulo 2^32 (PC 32'hFFFF_FFFC -> 32'h0000_0000).
REQ-024 State machine SHALL have states FETCH and HALTED; HALTED exits only by redirect or reset.
REQ-025 In HALTED without redirect: PC holds; IF/ID holds its last contents; fetch_count holds.
REQ-026 Single-cycle latency: an instruction accepted on edge N SHALL appear on instr_out after edge N.

Reset
REQ-027 RST high SHALL asynchronously set PC = PC_RESET, state = FETCH, instr_out = 0, PCInc_out = 0, valid_out = 0, halt_out = 0, fetch_count = 0.
REQ-028 RST asserted mid-miss or in HALTED SHALL discard all in-flight state; the first fetch after release SHALL be from PC_RESET.

Configuration
REQ-029 Macro FETCH_HALT_DETECT_EN SHALL gate halt detection.
REQ-030 With FETCH_HALT_DETECT_EN defined: an accepted ihit (per REQ-021) whose iload[31:26] == 6'h3F SHALL latch into IF/ID normally, leave PC unchanged, and move the state to HALTED.
REQ-031 Without FETCH_HALT_DETECT_EN: opcode 6'h3F SHALL be fetched as an ordinary instruction, HALTED SHALL be unreachable, and halt_out SHALL be tied 0.

Verification
REQ-032 Reset, then ihit=1 for 3 cycles with iload=A,B,C -> imemaddr 0,4,8,C; instr_out A,B,C; PCInc_out 4,8,C; fetch_count=3.
REQ-033 ihit=1 with stall=1 for 2 cycles at PC=8 -> PC stays 8; instr_out/fetch_count unchanged; PC advances to C when stall drops.
REQ-034 Same-cycle redirect=1, stall=1, ihit=1, redirect_pc=32'h0000_0043 -> PC=32'h0000_0040, valid_out=0, fetch_count unchanged.
REQ-035 Miss: ihit=0 for 2 cycles at PC=4 -> valid_out=0, imemaddr stays 4; next ihit latches the instruction with PCInc_out=8.
REQ-036 With FETCH_HALT_DETECT_EN: iload=32'hFC00_0000 with ihit -> next cycle halt_out=1, imemREN=0, valid_out=1; redirect to 32'h100 -> FETCH, imemaddr=32'h100. Without the macro -> PC advances and halt_out stays 0.
REQ-037 PC preset via redirect to 32'hFFFF_FFFC, then ihit -> PCInc_out=0 and next imemaddr=0; RST pulsed mid-miss -> imemaddr=PC_RESET asynchronously.
